rvh_ptw_mem_port: RTL and testbench



---
 rtl/rvh_ptw_mem_pkg.sv | 9 +
 rtl/rvh_ptw_mem_port_if.sv | 30 +++
 rtl/rvh_ptw_sync_fifo.sv | 41 ++++
 rtl/rvh_ptw_mem_port.sv | 76 +++++++
 tb/tb_rvh_ptw_mem_port.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rvh_ptw_mem_pkg.sv
// rvh_ptw_mem_pkg: shared constants and tag encoding for the PTW memory port.
package rvh_ptw_mem_pkg;
    localparam int PTE_WIDTH      = 64;
    localparam int PTE_ALIGN_BITS = 3;
    typedef enum logic {
        PTW_TAG_MEM    = 1'b0,
        PTW_TAG_BYPASS = 1'b1
    } ptw_tag_e;
endpackage

// File: rtl/rvh_ptw_mem_port_if.sv
// rvh_ptw_mem_port_if: walker request/response and memory read channels.
interface rvh_ptw_mem_port_if #(
    parameter int PTW_ID_WIDTH = 1,
    parameter int PADDR_WIDTH  = 56
);
    logic                    ptw_walk_req_vld;
    logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id;
    logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr;
    logic                    ptw_walk_req_rdy;
    logic                    ptw_walk_resp_vld;
    logic [63:0]             ptw_walk_resp_pte;
    logic                    ptw_walk_resp_rdy;
    logic                    mem_req_vld;
    logic [PADDR_WIDTH-1:0]  mem_req_addr;
    logic                    mem_req_rdy;
    logic                    mem_resp_vld;
    logic [63:0]             mem_resp_data;
    modport slave (
        input  ptw_walk_req_vld, ptw_walk_req_id, ptw_walk_req_addr, ptw_walk_resp_rdy,
        input  mem_req_rdy, mem_resp_vld, mem_resp_data,
        output ptw_walk_req_rdy, ptw_walk_resp_vld, ptw_walk_resp_pte,
        output mem_req_vld, mem_req_addr
    );
    modport master (
        output ptw_walk_req_vld, ptw_walk_req_id, ptw_walk_req_addr, ptw_walk_resp_rdy,
        output mem_req_rdy, mem_resp_vld, mem_resp_data,
        input  ptw_walk_req_rdy, ptw_walk_resp_vld, ptw_walk_resp_pte,
        input  mem_req_vld, mem_req_addr
    );
endinterface

// File: rtl/rvh_ptw_sync_fifo.sv
// rvh_ptw_sync_fifo: small synchronous FIFO with simultaneous push/pop.
module rvh_ptw_sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= nxt(wp);
            end
            if (pop) rp <= nxt(rp);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
    assign dout  = mem[rp];
    assign empty = cnt == '0;
    assign full  = cnt == CW'(DEPTH);
endmodule

// File: rtl/rvh_ptw_mem_port.sv
// rvh_ptw_mem_port: in-order PTE source for the MMU walker with credit-bounded outstanding reads.
// Optional RVH_PTW_MISALIGN_CHECK_EN: misaligned PTE addresses bypass memory and return PTE 0.
module rvh_ptw_mem_port
    import rvh_ptw_mem_pkg::*;
#(
    parameter int PTW_ID_WIDTH    = 1,
    parameter int PADDR_WIDTH     = 56,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic               clk,
    input logic               rstn,
    rvh_ptw_mem_port_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    logic [CW-1:0]          cnt;
    logic                   slot_vld;
    logic [PADDR_WIDTH-1:0] slot_addr;
    logic                   accept, bypass, pop, tag_bypass;
    logic                   tag_full, tag_empty, data_full, data_empty;
    logic [0:0]             tag_head;
    logic [PTE_WIDTH-1:0]   data_head;
    ptw_tag_e               tag_in;
    logic                   unused_ok;
`ifdef RVH_PTW_MISALIGN_CHECK_EN
    assign bypass = |bus.ptw_walk_req_addr[PTE_ALIGN_BITS-1:0];
`else
    assign bypass = 1'b0;
`endif
    // A full slot that memory is not draining this cycle cannot take a new read.
    assign bus.ptw_walk_req_rdy = (cnt < MAX_CNT) & ~(slot_vld & ~bus.mem_req_rdy);
    assign accept     = bus.ptw_walk_req_vld & bus.ptw_walk_req_rdy;
    assign tag_in     = bypass ? PTW_TAG_BYPASS : PTW_TAG_MEM;
    assign tag_bypass = tag_head == PTW_TAG_BYPASS;
    assign bus.ptw_walk_resp_vld = ~tag_empty & (tag_bypass | ~data_empty);
    assign bus.ptw_walk_resp_pte = (bus.ptw_walk_resp_vld & ~tag_bypass) ? data_head : '0;
    assign pop = bus.ptw_walk_resp_vld & bus.ptw_walk_resp_rdy;
    assign bus.mem_req_vld  = slot_vld;
    assign bus.mem_req_addr = slot_addr;
    assign unused_ok = ^{bus.ptw_walk_req_id, bus.ptw_walk_req_addr[PTE_ALIGN_BITS-1:0], tag_full, data_full};
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            slot_vld  <= 1'b0;
            slot_addr <= '0;
        end else begin
            cnt <= cnt + CW'(accept) - CW'(pop);
            if (accept & ~bypass) begin
                slot_vld  <= 1'b1;
                slot_addr <= {bus.ptw_walk_req_addr[PADDR_WIDTH-1:PTE_ALIGN_BITS], {PTE_ALIGN_BITS{1'b0}}};
            end else if (bus.mem_req_rdy) begin
                slot_vld <= 1'b0;
            end
        end
    end
    rvh_ptw_sync_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) tag_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (accept),
        .din   (tag_in),
        .pop   (pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );
    rvh_ptw_sync_fifo #(.WIDTH(PTE_WIDTH), .DEPTH(MAX_OUTSTANDING)) data_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.mem_resp_vld),
        .din   (bus.mem_resp_data),
        .pop   (pop & ~tag_bypass),
        .dout  (data_head),
        .full  (data_full),
        .empty (data_empty)
    );
endmodule

// File: tb/tb_rvh_ptw_mem_port.sv
// tb_rvh_ptw_mem_port: directed scoreboard bench for the PTW memory port.
module tb_rvh_ptw_mem_port;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [55:0] exp_addr[$];
    logic [55:0] mem_pend[$];
    rvh_ptw_mem_port_if #(.PTW_ID_WIDTH(1), .PADDR_WIDTH(56)) bus();
    rvh_ptw_mem_port #(.PTW_ID_WIDTH(1), .PADDR_WIDTH(56), .MAX_OUTSTANDING(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );
    always #5 clk = ~clk;
    function automatic logic [63:0] mem_data(input logic [55:0] a);
        return (a == 56'h80001000) ? 64'h20000001 : {8'hA5, a};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic req(input logic [55:0] a);
        bus.ptw_walk_req_vld  = 1'b1;
        bus.ptw_walk_req_addr = a;
    endtask
    task automatic mem_resp();
        logic [55:0] a;
        checks++;
        assert (mem_pend.size() != 0) else begin
            failures++;
            $error("FAIL mem_pend observed=empty expected=pending read");
        end
        if (mem_pend.size() != 0) begin
            a = mem_pend.pop_front();
            bus.mem_resp_vld  = 1'b1;
            bus.mem_resp_data = mem_data(a);
            tick();
            bus.mem_resp_vld = 1'b0;
        end
    endtask
    // Scoreboard: expectations are queued at accept and consumed at handshakes.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.ptw_walk_req_vld && bus.ptw_walk_req_rdy) begin
`ifdef RVH_PTW_MISALIGN_CHECK_EN
                if (bus.ptw_walk_req_addr[2:0] != 3'b000) exp_q.push_back(64'h0);
                else begin
                    exp_q.push_back(mem_data({bus.ptw_walk_req_addr[55:3], 3'b000}));
                    exp_addr.push_back({bus.ptw_walk_req_addr[55:3], 3'b000});
                end
`else
                exp_q.push_back(mem_data({bus.ptw_walk_req_addr[55:3], 3'b000}));
                exp_addr.push_back({bus.ptw_walk_req_addr[55:3], 3'b000});
`endif
            end
            if (bus.mem_req_vld && bus.mem_req_rdy) begin
                checks++;
                assert (exp_addr.size() != 0 && bus.mem_req_addr === exp_addr[0]) else begin
                    failures++;
                    $error("FAIL mem_addr observed=%h expected=%h", bus.mem_req_addr,
                           exp_addr.size() != 0 ? exp_addr[0] : 56'hx);
                end
                if (exp_addr.size() != 0) void'(exp_addr.pop_front());
                mem_pend.push_back(bus.mem_req_addr);
            end
            if (bus.ptw_walk_resp_vld && bus.ptw_walk_resp_rdy) begin
                checks++;
                assert (exp_q.size() != 0 && bus.ptw_walk_resp_pte === exp_q[0]) else begin
                    failures++;
                    $error("FAIL resp_pte observed=%h expected=%h", bus.ptw_walk_resp_pte,
                           exp_q.size() != 0 ? exp_q[0] : 64'hx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    end
    initial begin
        bus.ptw_walk_req_vld  = 1'b0;
        bus.ptw_walk_req_id   = 1'b0;
        bus.ptw_walk_req_addr = '0;
        bus.ptw_walk_resp_rdy = 1'b1;
        bus.mem_req_rdy       = 1'b1;
        bus.mem_resp_vld      = 1'b0;
        bus.mem_resp_data     = '0;
        #2;
        chk("rst_req_rdy", bus.ptw_walk_req_rdy, 1);
        chk("rst_resp_vld", bus.ptw_walk_resp_vld, 0);
        chk("rst_pte", bus.ptw_walk_resp_pte, 0);
        chk("rst_mem_vld", bus.mem_req_vld, 0);
        chk("rst_mem_addr", bus.mem_req_addr, 0);
        tick();
        rstn = 1'b1;
        tick();
        // single walk
        req(56'h80001000);
        tick();
        bus.ptw_walk_req_vld = 1'b0;
        chk("single_mem_vld", bus.mem_req_vld, 1);
        chk("single_mem_addr", bus.mem_req_addr, 56'h80001000);
        tick();
        chk("single_mem_vld_drop", bus.mem_req_vld, 0);
        tick();
        tick();
        chk("single_resp_idle", bus.ptw_walk_resp_vld, 0);
        mem_resp();
        chk("single_resp_vld", bus.ptw_walk_resp_vld, 1);
        chk("single_resp_pte", bus.ptw_walk_resp_pte, 64'h20000001);
        tick();
        chk("single_resp_done", bus.ptw_walk_resp_vld, 0);
        // three back-to-back with credit limit 2
        req(56'h80002000);
        tick();
        req(56'h80003000);
        tick();
        req(56'h80004000);
        chk("b2b_rdy_full", bus.ptw_walk_req_rdy, 0);
        tick();
        chk("b2b_rdy_full2", bus.ptw_walk_req_rdy, 0);
        mem_resp();
        chk("b2b_rdy_same_pop", bus.ptw_walk_req_rdy, 0);
        tick();
        chk("b2b_rdy_freed", bus.ptw_walk_req_rdy, 1);
        tick();
        bus.ptw_walk_req_vld = 1'b0;
        tick();
        mem_resp();
        mem_resp();
        tick();
        tick();
        // memory backpressure
        bus.mem_req_rdy = 1'b0;
        req(56'h80005000);
        tick();
        req(56'h80006000);
        for (int i = 0; i < 5; i++) begin
            chk("bp_mem_vld", bus.mem_req_vld, 1);
            chk("bp_mem_addr", bus.mem_req_addr, 56'h80005000);
            chk("bp_req_rdy", bus.ptw_walk_req_rdy, 0);
            tick();
        end
        bus.mem_req_rdy = 1'b1;
        #1;
        chk("bp_req_rdy_release", bus.ptw_walk_req_rdy, 1);
        tick();
        bus.ptw_walk_req_vld = 1'b0;
        chk("bp_next_addr", bus.mem_req_addr, 56'h80006000);
        tick();
        mem_resp();
        mem_resp();
        tick();
        tick();
        // misaligned address
        req(56'h80001004);
        tick();
        bus.ptw_walk_req_vld = 1'b0;
`ifdef RVH_PTW_MISALIGN_CHECK_EN
        chk("mis_no_mem", bus.mem_req_vld, 0);
        chk("mis_resp_vld", bus.ptw_walk_resp_vld, 1);
        chk("mis_resp_pte", bus.ptw_walk_resp_pte, 0);
        tick();
`else
        chk("mis_mem_vld", bus.mem_req_vld, 1);
        chk("mis_mem_addr", bus.mem_req_addr, 56'h80001000);
        tick();
        mem_resp();
        tick();
`endif
        tick();
        // response backpressure, then simultaneous accept + consume
        bus.ptw_walk_resp_rdy = 1'b0;
        req(56'h80007000);
        tick();
        bus.ptw_walk_req_vld = 1'b0;
        tick();
        mem_resp();
        for (int i = 0; i < 4; i++) begin
            chk("stall_vld", bus.ptw_walk_resp_vld, 1);
            chk("stall_pte", bus.ptw_walk_resp_pte, mem_data(56'h80007000));
            tick();
        end
        req(56'h80008000);
        bus.ptw_walk_resp_rdy = 1'b1;
        chk("sim_rdy", bus.ptw_walk_req_rdy, 1);
        tick();
        chk("sim_single_pop", bus.ptw_walk_resp_vld, 0);
        req(56'h80009000);
        chk("sim_cnt_kept", bus.ptw_walk_req_rdy, 1);
        tick();
        bus.ptw_walk_req_vld = 1'b0;
        chk("sim_cnt_full", bus.ptw_walk_req_rdy, 0);
        tick();
        chk("sim_outstanding", exp_q.size(), 2);
        // asynchronous reset with two walks outstanding
        rstn = 1'b0;
        #1;
        chk("arst_req_rdy", bus.ptw_walk_req_rdy, 1);
        chk("arst_resp_vld", bus.ptw_walk_resp_vld, 0);
        chk("arst_pte", bus.ptw_walk_resp_pte, 0);
        chk("arst_mem_vld", bus.mem_req_vld, 0);
        chk("arst_mem_addr", bus.mem_req_addr, 0);
        exp_q.delete();
        exp_addr.delete();
        mem_pend.delete();
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_resp_vld", bus.ptw_walk_resp_vld, 0);
        req(56'h8000A000);
        tick();
        bus.ptw_walk_req_vld = 1'b0;
        tick();
        mem_resp();
        chk("post_rst_pte", bus.ptw_walk_resp_pte, mem_data(56'h8000A000));
        tick();
        tick();
        chk("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
